// File: rtl/im_data_fetcher.sv
// Strided word fetcher: issues credit-limited memory reads and streams the
// in-order responses through a small FIFO toward the item-memory low-dim port.
module im_data_fetcher #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int CountWidth = 16,
    parameter int FifoDepth  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  start_i,
    input  logic [AddrWidth-1:0]  cfg_base_addr_i,
    input  logic [AddrWidth-1:0]  cfg_stride_i,
    input  logic [CountWidth-1:0] cfg_num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [AddrWidth-1:0]  mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DataWidth-1:0]  mem_rdata_i,
    output logic [DataWidth-1:0]  data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [CountWidth-1:0] DepthC  = CountWidth'(FifoDepth);
    localparam logic [PtrW-1:0]       LastPtr = PtrW'(FifoDepth - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [AddrWidth-1:0]  r_cur_addr;
    logic [AddrWidth-1:0]  r_stride;
    logic [CountWidth-1:0] r_num;
    logic [CountWidth-1:0] r_issued;
    logic [CountWidth-1:0] r_inflight;
    logic [CountWidth-1:0] r_discard;
    logic [CountWidth-1:0] r_fifo_cnt;
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic                  r_done;
    logic [DataWidth-1:0]  r_fifo [FifoDepth];

    logic                  w_gnt;
    logic                  w_rsp_discard;
    logic                  w_rsp_push;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [CountWidth-1:0] w_discard_load;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Credit rule: in-flight requests plus buffered words never exceed the FIFO depth.
    assign mem_req_o     = (r_state == S_FETCH) && (r_issued < r_num) &&
                           ((r_inflight + r_fifo_cnt) < DepthC);
    assign mem_addr_o    = r_cur_addr;
    assign w_gnt         = mem_req_o && mem_gnt_i;
    assign w_rsp_discard = mem_rvalid_i && (r_discard != '0);
    assign w_rsp_push    = mem_rvalid_i && (r_discard == '0) && (r_inflight != '0);
    assign w_fifo_empty  = (r_fifo_cnt == '0);
    assign w_pop         = !w_fifo_empty && data_ready_i;
    assign data_valid_o  = !w_fifo_empty;
    assign data_o        = w_fifo_empty ? '0 : r_fifo[r_rd_ptr];
    assign busy_o        = (r_state != S_IDLE) || (r_discard != '0);
    assign done_o        = r_done;

    // Everything still owed by the memory, including this cycle's grant, is discarded after a clear.
    assign w_discard_load = r_discard + r_inflight + CountWidth'(w_gnt)
                          - CountWidth'(w_rsp_push | w_rsp_discard);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_stride   <= '0;
            r_num      <= '0;
            r_issued   <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr_i) begin
                r_state    <= S_IDLE;
                r_inflight <= '0;
                r_discard  <= w_discard_load;
                r_fifo_cnt <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_rsp_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                r_fifo_cnt <= r_fifo_cnt + CountWidth'(w_rsp_push) - CountWidth'(w_pop);
                r_inflight <= r_inflight + CountWidth'(w_gnt) - CountWidth'(w_rsp_push);
                if (w_rsp_discard) begin
                    r_discard <= r_discard - CountWidth'(1);
                end
                if (w_gnt) begin
                    r_cur_addr <= r_cur_addr + r_stride;
                    r_issued   <= r_issued + CountWidth'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        if (start_i && (r_discard == '0)) begin
                            if (cfg_num_words_i != '0) begin
                                r_cur_addr <= cfg_base_addr_i;
                                r_stride   <= cfg_stride_i;
                                r_num      <= cfg_num_words_i;
                                r_issued   <= '0;
                                r_state    <= S_FETCH;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (w_gnt && ((r_issued + CountWidth'(1)) == r_num)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if ((r_inflight == '0) && w_fifo_empty) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_rsp_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_im_data_fetcher.sv
// Directed bench for im_data_fetcher: a simple in-order memory responder
// returns addr ^ 0xDEAD0000 one cycle after each grant.
module tb_im_data_fetcher;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic        start_i;
    logic [31:0] cfg_base_addr_i;
    logic [31:0] cfg_stride_i;
    logic [15:0] cfg_num_words_i;
    logic        busy_o;
    logic        done_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt;
    int          req_cycles;
    bit          auto_rsp;
    logic [31:0] gnt_addrs [$];
    logic [31:0] out_words [$];

    im_data_fetcher dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clr_i           (clr_i),
        .start_i         (start_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_stride_i    (cfg_stride_i),
        .cfg_num_words_i (cfg_num_words_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .data_o          (data_o),
        .data_valid_o    (data_valid_o),
        .data_ready_i    (data_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log what the DUT shows before the edge, then respond after it.
    task automatic tick();
        bit          fire;
        logic [31:0] a;
        fire = mem_req_o && mem_gnt_i;
        a    = mem_addr_o;
        if (fire) gnt_addrs.push_back(a);
        if (data_valid_o && data_ready_i) out_words.push_back(data_o);
        if (done_o) done_cnt++;
        if (mem_req_o) req_cycles++;
        @(posedge clk_i);
        #1;
        if (auto_rsp) begin
            mem_rvalid_i = fire;
            mem_rdata_i  = fire ? (a ^ 32'hDEAD0000) : 32'h0;
        end
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != 0) break;
        end
    endtask

    task automatic begin_xfer(input logic [31:0] base, input logic [31:0] stride,
                              input logic [15:0] num);
        gnt_addrs.delete();
        out_words.delete();
        done_cnt        = 0;
        req_cycles      = 0;
        cfg_base_addr_i = base;
        cfg_stride_i    = stride;
        cfg_num_words_i = num;
        start_i         = 1'b1;
        tick();
        start_i         = 1'b0;
    endtask

    initial begin
        logic [31:0] exp4 [4];
        logic [31:0] exp5 [5];
        logic [31:0] exp3 [3];

        rst_i = 1'b1; clr_i = 1'b0; start_i = 1'b0;
        cfg_base_addr_i = '0; cfg_stride_i = '0; cfg_num_words_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        data_ready_i = 1'b0; auto_rsp = 1'b0; done_cnt = 0; req_cycles = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", data_o, 0);

        // Basic 4-word transfer
        auto_rsp = 1'b1; mem_gnt_i = 1'b1; data_ready_i = 1'b1;
        begin_xfer(32'h100, 32'd4, 16'd4);
        run_until_done(60);
        check("basic_busy_after_done", busy_o, 0);
        repeat (3) tick();
        check("basic_done_once", done_cnt, 1);
        exp4 = '{32'h100, 32'h104, 32'h108, 32'h10C};
        check("basic_n_grants", gnt_addrs.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("basic_addr%0d", i),
                  (i < gnt_addrs.size()) ? gnt_addrs[i] : 32'hxxxxxxxx, exp4[i]);
        exp4 = '{32'hDEAD0100, 32'hDEAD0104, 32'hDEAD0108, 32'hDEAD010C};
        check("basic_n_words", out_words.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("basic_data%0d", i),
                  (i < out_words.size()) ? out_words[i] : 32'hxxxxxxxx, exp4[i]);

        // Backpressure: FIFO of 2 limits grants while ready is low
        data_ready_i = 1'b0;
        begin_xfer(32'h200, 32'd4, 16'd5);
        repeat (10) tick();
        req_cycles = 0;
        repeat (10) tick();
        check("bp_n_grants_stalled", gnt_addrs.size(), 2);
        check("bp_req_cycles_stalled", req_cycles, 0);
        check("bp_valid_stalled", data_valid_o, 1);
        check("bp_head_stalled", data_o, 32'hDEAD0200);
        data_ready_i = 1'b1;
        run_until_done(80);
        check("bp_done", done_cnt, 1);
        exp5 = '{32'hDEAD0200, 32'hDEAD0204, 32'hDEAD0208, 32'hDEAD020C, 32'hDEAD0210};
        check("bp_n_words", out_words.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("bp_data%0d", i),
                  (i < out_words.size()) ? out_words[i] : 32'hxxxxxxxx, exp5[i]);

        // Grant withheld for 3 cycles on the first request
        mem_gnt_i = 1'b0;
        begin_xfer(32'h100, 32'd4, 16'd2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_req%0d", i), mem_req_o, 1);
            check($sformatf("stall_addr%0d", i), mem_addr_o, 32'h100);
            tick();
        end
        mem_gnt_i = 1'b1;
        run_until_done(40);
        check("stall_done", done_cnt, 1);
        check("stall_n_grants", gnt_addrs.size(), 2);
        check("stall_addr_a", (gnt_addrs.size() > 0) ? gnt_addrs[0] : 32'hxxxxxxxx, 32'h100);
        check("stall_addr_b", (gnt_addrs.size() > 1) ? gnt_addrs[1] : 32'hxxxxxxxx, 32'h104);

        // Address wrap modulo 2^32
        begin_xfer(32'hFFFFFFF8, 32'd8, 16'd3);
        run_until_done(40);
        check("wrap_done", done_cnt, 1);
        exp3 = '{32'hFFFFFFF8, 32'h00000000, 32'h00000008};
        check("wrap_n_grants", gnt_addrs.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("wrap_addr%0d", i),
                  (i < gnt_addrs.size()) ? gnt_addrs[i] : 32'hxxxxxxxx, exp3[i]);

        // Clear with two requests in flight; their responses must be absorbed
        auto_rsp = 1'b0; mem_rvalid_i = 1'b0;
        begin_xfer(32'h300, 32'd4, 16'd4);
        repeat (3) tick();
        check("clr_grants_before", gnt_addrs.size(), 2);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_valid", data_valid_o, 0);
        check("clr_busy", busy_o, 1);
        check("clr_req", mem_req_o, 0);
        cfg_num_words_i = 16'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("clr_start_ignored_req", mem_req_o, 0);
        check("clr_busy_wait0", busy_o, 1);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD00001;
        tick();
        mem_rvalid_i = 1'b0;
        check("clr_busy_wait1", busy_o, 1);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD00002;
        tick();
        mem_rvalid_i = 1'b0;
        check("clr_busy_released", busy_o, 0);
        repeat (4) tick();
        check("clr_no_done", done_cnt, 0);
        check("clr_no_words", out_words.size(), 0);
        check("clr_no_new_grants", gnt_addrs.size(), 2);
        check("clr_idle_req", mem_req_o, 0);

        // Zero-length start
        begin_xfer(32'h400, 32'd4, 16'd0);
        check("zero_done_pulse", done_o, 1);
        check("zero_busy", busy_o, 0);
        tick();
        check("zero_done_cleared", done_o, 0);
        repeat (3) tick();
        check("zero_no_req", req_cycles, 0);

        // Reset mid-transfer, then a stray response after reset
        begin_xfer(32'h500, 32'd4, 16'd4);
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_busy", busy_o, 0);
        check("mrst_req", mem_req_o, 0);
        check("mrst_addr", mem_addr_o, 0);
        check("mrst_valid", data_valid_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD00003;
        tick();
        mem_rvalid_i = 1'b0;
        check("mrst_stray_dropped", data_valid_o, 0);
        check("mrst_stray_data", data_o, 0);
        repeat (3) tick();
        check("mrst_no_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/im_data_fetcher.md
IM_DATA_FETCHER -- requirements
Module: im_data_fetcher

Interface
REQ-001 Parameter DataWidth, default 32: width of a fetched word and of data_o (matches the item-memory low-dim port width).
REQ-002 Parameter AddrWidth, default 32: memory address width.
REQ-003 Parameter CountWidth, default 16: width of the word-count configuration and internal counters.
REQ-004 Parameter FifoDepth, default 2: output buffer depth, which is also the maximum number of requests in flight plus words buffered.
REQ-005 Clocking is a single clock; reset is synchronous and active-high.
REQ-006 Port clk_i, input, 1: clock; all logic is on its rising edge.
REQ-007 Port rst_i, input, 1: synchronous active-high reset.
REQ-008 Port clr_i, input, 1: synchronous soft clear (abort).
REQ-009 Port start_i, input, 1: start pulse; sampled only in IDLE.
REQ-010 Port cfg_base_addr_i, input, AddrWidth: first word address; sampled on an accepted start.
REQ-011 Port cfg_stride_i, input, AddrWidth: address increment per word; sampled on an accepted start.
REQ-012 Port cfg_num_words_i, input, CountWidth: number of words to fetch; sampled on an accepted start.
REQ-013 Port busy_o, output, 1: high whenever state is not IDLE or discard_cnt != 0.
REQ-014 Port done_o, output, 1: one-cycle completion pulse.
REQ-015 Port mem_req_o, output, 1: read request valid.
REQ-016 Port mem_addr_o, output, AddrWidth: read address.
REQ-017 Port mem_gnt_i, input, 1: request accepted.
REQ-018 Port mem_rvalid_i, input, 1: response valid.
REQ-019 Port mem_rdata_i, input, DataWidth: response data.
REQ-020 Port data_o, output, DataWidth: word toward the item memory (lowdim port).
REQ-021 Port data_valid_o, output, 1: valid toward the item memory.
REQ-022 Port data_ready_i, input, 1: ready from the item memory.

Function
REQ-023 The FSM SHALL have three states: IDLE, FETCH, DRAIN.
REQ-024 In IDLE, start_i with cfg_num_words_i > 0 SHALL latch the configuration, clear the counters, and enter FETCH next cycle.
REQ-025 In IDLE, start_i with cfg_num_words_i == 0 SHALL pulse done_o next cycle and remain in IDLE.
REQ-026 start_i SHALL be ignored while not in IDLE or while discard_cnt != 0.
REQ-027 In FETCH, mem_req_o SHALL be high iff issued < num_words and (inflight + fifo_count) < FifoDepth.
REQ-028 While mem_req_o is high and mem_gnt_i is low, mem_addr_o SHALL be held stable.
REQ-029 On mem_req_o && mem_gnt_i, the address SHALL advance by cur_addr + stride, truncated to AddrWidth (wraps modulo 2^AddrWidth), and issued/inflight SHALL increment.
REQ-030 When issued reaches num_words on a grant, the FSM SHALL enter DRAIN next cycle and mem_req_o SHALL be low.
REQ-031 Responses arrive in order, at least one cycle after their grant.
REQ-032 Each mem_rvalid_i SHALL push mem_rdata_i into the FIFO and decrement inflight.
REQ-033 A pushed word SHALL appear on data_o/data_valid_o the next cycle (1-cycle latency).
REQ-034 data_o SHALL equal the FIFO head.
REQ-035 data_valid_o SHALL equal !fifo_empty.
REQ-036 A word is popped on data_valid_o && data_ready_i.
REQ-037 Simultaneous push and pop SHALL keep fifo_count unchanged; the credit rule in REQ-027 makes overflow impossible.
REQ-038 Grant and response in the same cycle SHALL leave inflight unchanged.
REQ-039 In DRAIN, once inflight == 0 and the FIFO is empty, done_o SHALL pulse for one cycle and the FSM SHALL enter IDLE the same edge.
REQ-040 clr_i SHALL have priority over start_i and over all state activity: the FSM returns to IDLE, the FIFO is flushed, mem_req_o drops next cycle, and done_o is not pulsed.
REQ-041 On clr_i, discard_cnt SHALL load the inflight count, including a request granted in that same cycle.
REQ-042 While discard_cnt != 0, each mem_rvalid_i SHALL decrement discard_cnt and its data SHALL NOT enter the FIFO.
REQ-043 A mem_rvalid_i with inflight == 0 and discard_cnt == 0 is a protocol error and SHALL be dropped.

Reset
REQ-044 rst_i SHALL place the FSM in IDLE, clear all counters, discard_cnt and the FIFO, and drive busy_o, done_o, mem_req_o and data_valid_o to 0 and mem_addr_o and data_o to 0.
REQ-045 rst_i asserted mid-transfer SHALL behave as REQ-044 and SHALL NOT pulse done_o.
REQ-046 Responses arriving after rst_i SHALL be dropped (discard state is cleared).

Verification
REQ-047 Stimulus: base=0x100, stride=4, num=4, gnt=1, rvalid one cycle after grant, ready=1. Required: addresses 0x100/0x104/0x108/0x10C, data_o sequence matches, done_o pulses once, busy_o low the cycle after done.
REQ-048 Stimulus: ready=0 with FifoDepth=2, num=5. Required: exactly 2 grants, mem_req_o low thereafter; after ready=1, all 5 words are delivered in order.
REQ-049 Stimulus: gnt low for 3 cycles on the first request. Required: mem_req_o and mem_addr_o=0x100 stable throughout; no address skipped.
REQ-050 Stimulus: base=0xFFFFFFF8, stride=8, num=3. Required: addresses 0xFFFFFFF8, 0x00000000, 0x00000008.
REQ-051 Stimulus: clr_i with 2 requests in flight. Required: next cycle IDLE, data_valid_o=0, busy_o high until 2 rvalids are absorbed, no data emitted, no done_o; a start_i in between is ignored.
REQ-052 Stimulus: start with num=0. Required: done_o pulse the next cycle and no mem_req_o.
